// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter states, frame geometry
// and the clocks-per-bit derivation.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int FRAME_BITS   = 10;
  localparam int GUARD_CYCLES = 2;
  localparam int CNT_W        = 17;

  function automatic int clocks_per_bit(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin pick, searching upward from the
// requester after last_grant and wrapping 3 -> 0.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid
);

  logic [1:0] cand;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_grant + 2'(k);
      if (req[cand]) begin
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one UART transmitter between four byte sources,
// one frame at a time, round-robin.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int CLOCK_SPEED    = 100_000_000,
  parameter int BAUD_RATE      = 9600,
  parameter int CLOCKS_PER_BIT = clocks_per_bit(CLOCK_SPEED, BAUD_RATE)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ack,
  output logic        tx_start_en,
  output logic [7:0]  tx_data,
  output logic        busy
);

  localparam int FRAME_CYCLES =
    FRAME_BITS * CLOCKS_PER_BIT + GUARD_CYCLES;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(FRAME_CYCLES - 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [1:0]        last_grant, last_nx;
  logic [1:0]        win, win_nx;
  logic [3:0]        ack_nx;
  logic              start_nx;
  logic [7:0]        data_nx;
  logic              busy_nx;
  logic [1:0]        grant_idx;
  logic              grant_valid;

  rr_arbiter4 u_rr (
    .req         (req),
    .last_grant  (last_grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    last_nx  = last_grant;
    win_nx   = win;
    ack_nx   = '0;
    start_nx = 1'b0;
    data_nx  = tx_data;
    unique case (state)
      IDLE: begin
        if (grant_valid) begin
          state_nx = ISSUE;
          win_nx   = grant_idx;
          data_nx  = req_data[8*grant_idx +: 8];
          start_nx = 1'b1;
          ack_nx   = 4'b0001 << grant_idx;
        end
      end
      ISSUE: begin
        state_nx = WAIT;
        cnt_nx   = '0;
        last_nx  = win;
      end
      WAIT: begin
        if (cnt == CNT_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_grant  <= 2'd3;
      win         <= '0;
      req_ack     <= '0;
      tx_start_en <= 1'b0;
      tx_data     <= 8'h00;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      last_grant  <= last_nx;
      win         <= win_nx;
      req_ack     <= ack_nx;
      tx_start_en <= start_nx;
      tx_data     <= data_nx;
      busy        <= busy_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized self-checking bench for uart_tx_arb with a
// transaction-level model and a serial-line decoder.
module tb_uart_tx_arb;

  localparam int CPB     = 4;
  localparam int FRAME   = 10 * CPB + 2;
  localparam int SPACING = FRAME + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ack;
  logic        tx_start_en;
  logic [7:0]  tx_data;
  logic        busy;

  always #5 clk = ~clk;

  uart_tx_arb #(.CLOCKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .tx_start_en (tx_start_en),
    .tx_data     (tx_data),
    .busy        (busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Model: a grant happens at any edge where the arbiter is
  // free and some req is high; it is free again SPACING edges
  // after a grant. Busy spans the ISSUE cycle plus FRAME.
  int         e = 0;
  int         last_g;
  int         free_e;
  int         issue_e;
  logic [7:0] exp_data;
  logic [3:0] last_ack;
  logic       last_xs;
  logic [7:0] exp_rx[$];
  int         dut_grant[$];
  int         dut_edge[$];

  task automatic model_reset();
    last_g   = 3;
    free_e   = 0;
    issue_e  = -1000;
    exp_data = 8'h00;
    last_ack = '0;
    last_xs  = 1'b0;
    exp_rx.delete();
  endtask

  task automatic step();
    logic [3:0] xa;
    logic       xs;
    logic       found;
    int         w;
    int         c;
    @(posedge clk);
    e++;
    xa = '0;
    xs = 1'b0;
    if (e >= free_e && req != 0) begin
      found = 1'b0;
      w = 0;
      for (int k = 1; k <= 4; k++) begin
        c = (last_g + k) % 4;
        if (!found && req[c]) begin
          w = c;
          found = 1'b1;
        end
      end
      xs       = 1'b1;
      xa       = 4'(1 << w);
      exp_data = req_data[8*w +: 8];
      last_g   = w;
      issue_e  = e;
      free_e   = e + SPACING;
      exp_rx.push_back(exp_data);
    end
    last_ack = xa;
    last_xs  = xs;
    @(negedge clk);
    check("start", 32'(tx_start_en), 32'(xs));
    check("ack", 32'(req_ack), 32'(xa));
    check("data", 32'(tx_data), 32'(exp_data));
    check("busy", 32'(busy),
          32'(e >= issue_e && e < issue_e + 1 + FRAME));
    if (tx_start_en) begin
      for (int i = 0; i < 4; i++)
        if (req_ack[i]) dut_grant.push_back(i);
      dut_edge.push_back(e);
    end
  endtask

  task automatic cyc(input bit keep);
    step();
    if (!keep) req = req & ~last_ack;
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (!last_xs && n < 10) begin
      cyc(1'b1);
      n++;
    end
    check(tag, 32'(last_xs), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(tx_start_en), 32'd0);
    check("rst_ack", 32'(req_ack), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Stand-in transmitter: one-cycle entry latency, 10 bits
  // of CPB clocks each, LSB first.
  logic       line = 1'b1;
  logic [9:0] sh = '1;
  int         ser_t = 0;
  logic       ser_on = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      line   <= 1'b1;
      ser_on <= 1'b0;
      ser_t  <= 0;
    end else if (tx_start_en) begin
      check("overlap", 32'(ser_on), 32'd0);
      sh     <= {1'b1, tx_data, 1'b0};
      ser_on <= 1'b1;
      ser_t  <= 0;
    end else if (ser_on) begin
      if (ser_t == 10 * CPB) begin
        line   <= 1'b1;
        ser_on <= 1'b0;
      end else begin
        line  <= sh[ser_t / CPB];
        ser_t <= ser_t + 1;
      end
    end
  end

  int         rx_t = 0;
  logic       rx_on = 1'b0;
  logic [7:0] rx_b = '0;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      rx_on <= 1'b0;
      rx_t  <= 0;
    end else if (!rx_on) begin
      if (!line) begin
        rx_on <= 1'b1;
        rx_t  <= 1;
      end
    end else begin
      rx_t <= rx_t + 1;
      for (int k = 1; k <= 8; k++)
        if (rx_t == k * CPB + CPB / 2) rx_b[k-1] <= line;
      if (rx_t == 9 * CPB + CPB / 2) begin
        rx_on <= 1'b0;
        check("rx_stop", 32'(line), 32'd1);
        check("rx_pending", 32'(exp_rx.size() > 0), 32'd1);
        if (exp_rx.size() > 0)
          check("rx_byte", 32'(rx_b), 32'(exp_rx.pop_front()));
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst0_start", 32'(tx_start_en), 32'd0);
    check("rst0_ack", 32'(req_ack), 32'd0);
    check("rst0_data", 32'(tx_data), 32'd0);
    check("rst0_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // single request from requester 2
    req = 4'b0100;
    req_data = 32'h00A5_0000;
    repeat (60) cyc(1'b0);

    // all four held after a fresh reset
    do_reset();
    req = 4'b1111;
    req_data = 32'h1312_1110;
    dut_grant.delete();
    dut_edge.delete();
    repeat (4 * SPACING + 2) cyc(1'b1);
    check("all_cnt", 32'(dut_grant.size()), 32'd5);
    if (dut_grant.size() >= 5) begin
      for (int i = 0; i < 5; i++)
        check("all_order", 32'(dut_grant[i]), 32'(i % 4));
      for (int i = 1; i < 5; i++)
        check("all_gap", 32'(dut_edge[i] - dut_edge[i-1]),
              32'(SPACING));
    end
    req = 4'b0000;
    repeat (SPACING) cyc(1'b0);

    // grant to 1, then 0011 held
    req = 4'b0010;
    wait_issue("g1_issue");
    req = 4'b0000;
    repeat (SPACING) cyc(1'b0);
    req = 4'b0011;
    dut_grant.delete();
    repeat (2 * SPACING) cyc(1'b1);
    check("rr_cnt", 32'(dut_grant.size()), 32'd2);
    if (dut_grant.size() >= 2) begin
      check("rr_first", 32'(dut_grant[0]), 32'd0);
      check("rr_second", 32'(dut_grant[1]), 32'd1);
    end
    req = 4'b0000;
    repeat (SPACING) cyc(1'b0);

    // request raised and dropped inside WAIT
    req = 4'b0100;
    req_data = 32'h0077_0000;
    wait_issue("drop_issue");
    req = 4'b0000;
    repeat (5) cyc(1'b0);
    req = 4'b0001;
    req_data[7:0] = 8'h3C;
    repeat (15) cyc(1'b1);
    req = 4'b0000;
    repeat (SPACING + 20) cyc(1'b0);

    // reset mid-WAIT, then requester 3 only
    req = 4'b0010;
    req_data = 32'h0000_9900;
    wait_issue("mid_issue");
    req = 4'b0000;
    repeat (20) cyc(1'b0);
    do_reset();
    req = 4'b1000;
    req_data = 32'h5A00_0000;
    wait_issue("post_rst");
    check("post_rst_ack", 32'(last_ack), 32'b1000);
    repeat (SPACING) cyc(1'b0);
    req = 4'b0000;
    repeat (SPACING) cyc(1'b0);

    // randomized requesters honouring hold-until-ack
    for (int n = 0; n < 3000; n++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        if (last_ack[i]) begin
          if ($urandom_range(1) == 0) req[i] = 1'b0;
          else req_data[8*i +: 8] = 8'($urandom);
        end else if (!req[i]) begin
          if ($urandom_range(7) == 0) begin
            req[i] = 1'b1;
            req_data[8*i +: 8] = 8'($urandom);
          end
        end else if (e + 1 < free_e && $urandom_range(39) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = 4'b0000;
    repeat (SPACING + 10) cyc(1'b0);
    check("rx_drain", 32'(exp_rx.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
